sdram_burst_reader: RTL
=======================

Name: sdram_burst_reader

Overview:
Parametrised SDRAM read engine that sits between the Avalon-MM read-master control/user ports and the SPI transmit path.
- Runs one burst per start request, with a host-programmed length, from an incrementing address.
- Drains the master's show-ahead read FIFO only when data is really available.
- Delivers words downstream over a valid/ready handshake.
- Auto-advances the read pointer between bursts and wraps inside a configured SDRAM region, so the RPi can stream a capture buffer repeatedly.

Parameters:
DATA_WIDTH, 32, width of read data word (multiple of 8)
ADDR_WIDTH, 32, byte address width
LEN_WIDTH, 32, byte length width
REGION_BASE, 0, first byte address of the readable region
REGION_BYTES, 32'h0400_0000, region size in bytes (multiple of DATA_WIDTH/8)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start_read  in  1  burst request; sampled only in IDLE
cfg_load  in  1  in IDLE, load read pointer from cfg_base
cfg_base  in  ADDR_WIDTH  new read pointer
cfg_length  in  LEN_WIDTH  burst length in bytes; latched at start
read_control_done  in  1  master finished the transfer
read_control_early_done  in  1  master issued its last read (informational only)
user_read_buffer_data  in  DATA_WIDTH  head of the master read FIFO (show-ahead)
user_read_data_available  in  1  FIFO non-empty
read_control_fixed_location  out  1  constant 0 (incrementing address)
control_read_base  out  ADDR_WIDTH  burst base address
control_read_length  out  LEN_WIDTH  burst length in bytes
read_control_go  out  1  one-cycle start pulse to the master
user_read_ack  out  1  FIFO pop
data_out  out  DATA_WIDTH  word to SPI
data_valid  out  1  data_out holds a valid word
data_ready  in  1  SPI accepts the word
busy  out  1  high in any state other than IDLE
burst_done  out  1  one-cycle pulse at the end of a burst
cfg_error  out  1  one-cycle pulse when a start request is rejected

Behaviour:
- Reset values: all outputs are 0, except control_read_base = REGION_BASE; the read pointer is REGION_BASE; the state is IDLE.
- BPW = DATA_WIDTH/8.
- A start request is invalid if any of these hold:
  - cfg_length == 0;
  - cfg_length mod BPW != 0;
  - cfg_length > REGION_BYTES.
- IDLE:
  - cfg_load=1 sets pointer <= cfg_base. If both cfg_load and start_read are high in the same cycle, cfg_load has priority and start is ignored that cycle.
  - start_read=1 with an invalid length: cfg_error pulses for 1 cycle; the block stays in IDLE.
  - start_read=1 with a valid length:
    - latch len <= cfg_length and words_left <= cfg_length/BPW;
    - base <= pointer, except when pointer+len > REGION_BASE+REGION_BYTES, in which case base <= REGION_BASE;
    - go to GO.
- GO: read_control_go=1 for exactly this cycle. control_read_base and control_read_length are stable from this cycle until burst_done. Next state is STREAM.
- STREAM:
  - A pop happens when user_read_data_available=1, words_left!=0, and the output register is either empty or being drained this cycle (data_valid & data_ready).
  - In a pop cycle: user_read_ack=1 for that cycle, data_out <= user_read_buffer_data, data_valid <= 1, and words_left decrements.
  - Throughput is 1 word per clock when data_ready is held high.
  - data_valid stays high, with data_out stable, until data_ready is sampled high.
  - A simultaneous drain and pop keeps data_valid at 1 with the new word.
  - user_read_ack is never asserted while user_read_data_available=0.
- STREAM exit: when words_left==0, read_control_done has been seen (sticky flag, can arrive before the last pop), and the output register is empty or draining → DONE.
- DONE:
  - burst_done pulses for 1 cycle.
  - pointer <= base+len, or REGION_BASE if base+len equals REGION_BASE+REGION_BYTES.
  - Next state is IDLE.
- start_read and cfg_load are ignored while busy.
- Reset in mid-burst returns to IDLE immediately and drops data_valid. The master must be reset by the same reset; the block does not support abort.
- Address arithmetic is modulo 2^ADDR_WIDTH. The region bounds are checked without overflow, using an ADDR_WIDTH+1-bit sum.

Test Plan:
1. Reset, then start with cfg_length=64 and data_ready=1, FIFO supplying 16 words → go at base 0 with length 64. Exactly 16 acks and 16 data_valid beats, in order. burst_done pulses. Pointer = 0x40.
2. Backpressure: with data_ready toggling 1/0 and the FIFO always available → no word lost or duplicated, data_out stable while stalled, ack only on pop cycles.
3. FIFO gaps: user_read_data_available deasserted for 3 cycles mid-burst → no ack during the gap. read_control_done asserted before the last pop still ends the burst only after word 16 is handed off.
4. Wrap: REGION_BYTES=256, cfg_load with cfg_base=0xC0, then start with length 128 → base wraps to 0x00. A second start of 128 reads from 0x80, then the pointer wraps to 0x00.
5. Bad config: cfg_length=0, 6, or 512 (with REGION_BYTES=256) → cfg_error pulses, no go, busy stays 0.
6. Reset asserted on word 5 of a 16-word burst → next cycle all outputs are at reset values and the pointer is REGION_BASE. A new start then works normally.

Source files
------------

// File: rtl/sdram_burst_reader.sv
// Burst read engine: launches one Avalon-MM read-master burst per start request,
// drains the show-ahead FIFO into a valid/ready output register, wraps inside a region.
module sdram_burst_reader #(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    LEN_WIDTH    = 32,
   parameter logic [ADDR_WIDTH-1:0] REGION_BASE  = '0,
   parameter logic [LEN_WIDTH-1:0]  REGION_BYTES = 32'h0400_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_read,
   input  logic                  cfg_load,
   input  logic [ADDR_WIDTH-1:0] cfg_base,
   input  logic [LEN_WIDTH-1:0]  cfg_length,
   input  logic                  read_control_done,
   input  logic                  read_control_early_done,
   input  logic [DATA_WIDTH-1:0] user_read_buffer_data,
   input  logic                  user_read_data_available,
   output logic                  read_control_fixed_location,
   output logic [ADDR_WIDTH-1:0] control_read_base,
   output logic [LEN_WIDTH-1:0]  control_read_length,
   output logic                  read_control_go,
   output logic                  user_read_ack,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   input  logic                  data_ready,
   output logic                  busy,
   output logic                  burst_done,
   output logic                  cfg_error
);

   localparam int                   BPW        = DATA_WIDTH / 8;
   localparam logic [LEN_WIDTH-1:0] BPW_L      = LEN_WIDTH'(BPW);
   // Region end kept one bit wider so base+size never overflows the compare.
   localparam logic [ADDR_WIDTH:0]  REGION_END = {1'b0, REGION_BASE} + (ADDR_WIDTH+1)'(REGION_BYTES);

   typedef enum logic [1:0] {S_IDLE, S_GO, S_STREAM, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d, base_q, base_d;
   logic [LEN_WIDTH-1:0]    len_q, len_d, words_left_q, words_left_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    valid_q, valid_d, done_seen_q, done_seen_d, cfg_error_q, cfg_error_d;

   logic                    len_bad, pop, drain, stream_end;
   logic [ADDR_WIDTH:0]     start_end, burst_end;
   logic                    unused;

   assign unused     = read_control_early_done;
   assign len_bad    = (cfg_length == '0) || ((cfg_length % BPW_L) != '0) || (cfg_length > REGION_BYTES);
   assign start_end  = {1'b0, ptr_q} + (ADDR_WIDTH+1)'(cfg_length);
   assign burst_end  = {1'b0, base_q} + (ADDR_WIDTH+1)'(len_q);
   assign drain      = valid_q & data_ready;
   assign pop        = (state_q == S_STREAM) & user_read_data_available &
                       (words_left_q != '0) & (~valid_q | data_ready);
   // done may arrive before the last pop; the flag holds it until the data is out.
   assign stream_end = (words_left_q == '0) & (done_seen_q | read_control_done) & (~valid_q | data_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         ptr_q        <= REGION_BASE;
         base_q       <= REGION_BASE;
         len_q        <= '0;
         words_left_q <= '0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         done_seen_q  <= 1'b0;
         cfg_error_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         base_q       <= base_d;
         len_q        <= len_d;
         words_left_q <= words_left_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         done_seen_q  <= done_seen_d;
         cfg_error_q  <= cfg_error_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start_read && !cfg_load && !len_bad) state_d = S_GO;
         S_GO:     state_d = S_STREAM;
         S_STREAM: if (stream_end) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ptr_d        = ptr_q;
      base_d       = base_q;
      len_d        = len_q;
      words_left_d = words_left_q;
      data_d       = data_q;
      valid_d      = valid_q;
      done_seen_d  = done_seen_q;
      cfg_error_d  = 1'b0;
      if (state_q == S_IDLE) begin
         if (cfg_load) begin
            ptr_d = cfg_base;
         end else if (start_read) begin
            if (len_bad) begin
               cfg_error_d = 1'b1;
            end else begin
               len_d        = cfg_length;
               words_left_d = cfg_length / BPW_L;
               done_seen_d  = 1'b0;
               base_d       = (start_end > REGION_END) ? REGION_BASE : ptr_q;
            end
         end
      end
      if ((state_q == S_GO || state_q == S_STREAM) && read_control_done) done_seen_d = 1'b1;
      if (pop) begin
         data_d       = user_read_buffer_data;
         valid_d      = 1'b1;
         words_left_d = words_left_q - LEN_WIDTH'(1);
      end else if (drain) begin
         valid_d = 1'b0;
      end
      if (state_q == S_DONE)
         ptr_d = (burst_end == REGION_END) ? REGION_BASE : burst_end[ADDR_WIDTH-1:0];
   end

   always_comb begin
      read_control_fixed_location = 1'b0;
      control_read_base           = base_q;
      control_read_length         = len_q;
      read_control_go             = (state_q == S_GO);
      user_read_ack               = pop;
      data_out                    = data_q;
      data_valid                  = valid_q;
      busy                        = (state_q != S_IDLE);
      burst_done                  = (state_q == S_DONE);
      cfg_error                   = cfg_error_q;
   end

endmodule
